// File: rtl/axi_mem_controller_register_file_if.sv
// Bus bundle for axi_mem_controller_register_file.
// Carries the two byte-enabled write ports, the read request, and the registered results.
//   master : drives write/read requests, observes read_data/read_valid/collision/addr_error
//   slave  : the register file itself
interface axi_mem_controller_register_file_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned BE_WIDTH   = 4,
    parameter int unsigned WIDTH      = 32
);
    // port A write
    logic                  write_en_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [WIDTH-1:0]      write_data_a;
    logic [BE_WIDTH-1:0]   byte_en_a;
    // port B write
    logic                  write_en_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [WIDTH-1:0]      write_data_b;
    logic [BE_WIDTH-1:0]   byte_en_b;
    // read request and results
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [WIDTH-1:0]      read_data;
    logic                  read_valid;
    logic                  collision;
    logic                  addr_error;

    modport master (
        output write_en_a, addr_a, write_data_a, byte_en_a,
        output write_en_b, addr_b, write_data_b, byte_en_b,
        output read_en, read_addr,
        input  read_data, read_valid, collision, addr_error
    );

    modport slave (
        input  write_en_a, addr_a, write_data_a, byte_en_a,
        input  write_en_b, addr_b, write_data_b, byte_en_b,
        input  read_en, read_addr,
        output read_data, read_valid, collision, addr_error
    );
endinterface

// File: rtl/axi_mem_controller_register_file.sv
// Register bank of NUM_REGS words holding per-channel control/status behind the AXI
// memory controller. Two byte-enabled write ports (A has priority per lane over B on the
// same word), one read port with a latency+1 deep {valid,data} pipeline.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : axi_mem_controller_register_file_if.slave (write A/B, read, read_data,
//            read_valid, collision, addr_error; all outputs registered)
// Optional feature macro: REGFILE_WRITE_BYPASS_EN -- a read returns the post-write word of
// a same-cycle write to the same address. Undefined: reads see the pre-write contents.
module axi_mem_controller_register_file #(
    parameter int unsigned     NUM_REGS      = 8,
    parameter int unsigned     ADDR_WIDTH    = 3,
    parameter int unsigned     byte_en_width = 4,
    parameter int unsigned     byte_size     = 8,
    parameter int unsigned     width         = 32,
    parameter logic [width-1:0] init_value   = '0,
    parameter int unsigned     latency       = 0
) (
    input  logic clk,
    input  logic reset,
    axi_mem_controller_register_file_if.slave bus
);

    logic [width-1:0] r_mem  [NUM_REGS];
    logic [width-1:0] w_next [NUM_REGS];
    logic [width-1:0] w_rd_word;

    logic             w_a_in_range;
    logic             w_b_in_range;
    logic             w_rd_in_range;
    logic             w_collision;
    logic             w_addr_error;

    logic             w_out_valid;
    logic [width-1:0] w_out_data;

    logic [width-1:0] r_read_data;
    logic             r_read_valid;
    logic             r_collision;
    logic             r_addr_error;

    assign w_a_in_range  = 32'(bus.addr_a)    < NUM_REGS;
    assign w_b_in_range  = 32'(bus.addr_b)    < NUM_REGS;
    assign w_rd_in_range = 32'(bus.read_addr) < NUM_REGS;

    // Same in-range word with at least one shared lane.
    assign w_collision = bus.write_en_a && bus.write_en_b && w_a_in_range &&
                         (bus.addr_a == bus.addr_b) && ((bus.byte_en_a & bus.byte_en_b) != '0);

    assign w_addr_error = (bus.write_en_a && !w_a_in_range) ||
                          (bus.write_en_b && !w_b_in_range) ||
                          (bus.read_en    && !w_rd_in_range);

    // Post-write array image; B is applied first so A overwrites shared lanes.
    // Out-of-range addresses match no word, so those writes fall away naturally.
    always_comb begin
        for (int j = 0; j < int'(NUM_REGS); j++) begin
            w_next[j] = r_mem[j];
            for (int i = 0; i < int'(byte_en_width); i++) begin
                if (bus.write_en_b && bus.byte_en_b[i] && (bus.addr_b == ADDR_WIDTH'(j))) begin
                    w_next[j][i*byte_size +: byte_size] = bus.write_data_b[i*byte_size +: byte_size];
                end
                if (bus.write_en_a && bus.byte_en_a[i] && (bus.addr_a == ADDR_WIDTH'(j))) begin
                    w_next[j][i*byte_size +: byte_size] = bus.write_data_a[i*byte_size +: byte_size];
                end
            end
        end
    end

    // Read word select; an out-of-range address matches nothing and yields 0.
    always_comb begin
        w_rd_word = '0;
        for (int j = 0; j < int'(NUM_REGS); j++) begin
            if (bus.read_addr == ADDR_WIDTH'(j)) begin
`ifdef REGFILE_WRITE_BYPASS_EN
                w_rd_word = w_next[j];
`else
                w_rd_word = r_mem[j];
`endif
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < int'(NUM_REGS); j++) begin
                r_mem[j] <= init_value;
            end
        end else begin
            for (int j = 0; j < int'(NUM_REGS); j++) begin
                r_mem[j] <= w_next[j];
            end
        end
    end

    // Extra read stages ahead of the output register.
    if (latency == 0) begin : g_no_pipe
        assign w_out_valid = bus.read_en;
        assign w_out_data  = w_rd_word;
    end else begin : g_pipe
        logic [latency-1:0] r_pipe_valid;
        logic [width-1:0]   r_pipe_data [latency];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pipe_valid <= '0;
                for (int k = 0; k < int'(latency); k++) begin
                    r_pipe_data[k] <= '0;
                end
            end else begin
                r_pipe_valid[0] <= bus.read_en;
                r_pipe_data[0]  <= w_rd_word;
                for (int k = 1; k < int'(latency); k++) begin
                    r_pipe_valid[k] <= r_pipe_valid[k-1];
                    r_pipe_data[k]  <= r_pipe_data[k-1];
                end
            end
        end

        assign w_out_valid = r_pipe_valid[latency-1];
        assign w_out_data  = r_pipe_data[latency-1];
    end

    // Output stage; read_data only moves on a valid beat so it holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_collision  <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            r_read_valid <= w_out_valid;
            if (w_out_valid) begin
                r_read_data <= w_out_data;
            end
            r_collision  <= w_collision;
            r_addr_error <= w_addr_error;
        end
    end

    assign bus.read_data  = r_read_data;
    assign bus.read_valid = r_read_valid;
    assign bus.collision  = r_collision;
    assign bus.addr_error = r_addr_error;

endmodule

// File: tb/tb_axi_mem_controller_register_file.sv
// Bench for axi_mem_controller_register_file: two instances driven with identical stimulus,
// dut0 (NUM_REGS=8, latency=0) and dut1 (NUM_REGS=6, latency=3). Reads are scored through
// per-instance queues of {expected data, due cycle}; flags are checked every cycle.
module tb_axi_mem_controller_register_file;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_mem_controller_register_file_if #(.ADDR_WIDTH(3), .BE_WIDTH(4), .WIDTH(32)) if0 ();
    axi_mem_controller_register_file_if #(.ADDR_WIDTH(3), .BE_WIDTH(4), .WIDTH(32)) if1 ();

    axi_mem_controller_register_file #(
        .NUM_REGS(8), .ADDR_WIDTH(3), .byte_en_width(4), .byte_size(8),
        .width(32), .init_value(32'h0), .latency(0)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    axi_mem_controller_register_file #(
        .NUM_REGS(6), .ADDR_WIDTH(3), .byte_en_width(4), .byte_size(8),
        .width(32), .init_value(32'h0), .latency(3)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    typedef struct {
        logic        we_a;
        logic [2:0]  addr_a;
        logic [31:0] data_a;
        logic [3:0]  be_a;
        logic        we_b;
        logic [2:0]  addr_b;
        logic [31:0] data_b;
        logic [3:0]  be_b;
        logic        re;
        logic [2:0]  raddr;
        logic        exp_coll;   // expected dut0 collision on the next cycle
        logic        exp_aerr;   // expected dut0 addr_error on the next cycle
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [31:0] m    [2][8];
    logic [31:0] last [2];
    logic        ec   [2];
    logic        ea   [2];
    rd_t         q0[$];
    rd_t         q1[$];
    vec_t        tbl [16];
    vec_t        idle;

    function automatic int unsigned nregs(int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] dat, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = dat[i*8 +: 8];
        return r;
    endfunction

    function automatic logic f_coll(vec_t v, int unsigned n);
        return v.we_a && v.we_b && (v.addr_a == v.addr_b) && (32'(v.addr_a) < n) &&
               ((v.be_a & v.be_b) != 4'h0);
    endfunction

    function automatic logic f_aerr(vec_t v, int unsigned n);
        return (v.we_a && 32'(v.addr_a) >= n) || (v.we_b && 32'(v.addr_b) >= n) ||
               (v.re && 32'(v.raddr) >= n);
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%08h, want 0x%08h", name, d, cyc, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        if0.write_en_a = v.we_a;  if1.write_en_a = v.we_a;
        if0.addr_a = v.addr_a;    if1.addr_a = v.addr_a;
        if0.write_data_a = v.data_a; if1.write_data_a = v.data_a;
        if0.byte_en_a = v.be_a;   if1.byte_en_a = v.be_a;
        if0.write_en_b = v.we_b;  if1.write_en_b = v.we_b;
        if0.addr_b = v.addr_b;    if1.addr_b = v.addr_b;
        if0.write_data_b = v.data_b; if1.write_data_b = v.data_b;
        if0.byte_en_b = v.be_b;   if1.byte_en_b = v.be_b;
        if0.read_en = v.re;       if1.read_en = v.re;
        if0.read_addr = v.raddr;  if1.read_addr = v.raddr;
    endtask

    task automatic check_dut(int d, logic v, logic [31:0] data, logic c, logic a);
        rd_t f;
        bit  has;
        has = 1'b0;
        chk("collision", d, 32'(c), 32'(ec[d]));
        chk("addr_error", d, 32'(a), 32'(ea[d]));
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin has = 1'b1; f = q0.pop_front(); end
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin has = 1'b1; f = q1.pop_front(); end
        end
        if (has) begin
            chk("read_valid", d, 32'(v), 32'h1);
            chk("read_data", d, data, f.data);
            last[d] = f.data;
        end else begin
            chk("read_valid", d, 32'(v), 32'h0);
            chk("read_data_hold", d, data, last[d]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_dut(0, if0.read_valid, if0.read_data, if0.collision, if0.addr_error);
        check_dut(1, if1.read_valid, if1.read_data, if1.collision, if1.addr_error);
    endtask

    // Update the model for both instances, queue expected reads, drive, advance one cycle.
    task automatic apply(vec_t v);
        for (int d = 0; d < 2; d++) begin
            int unsigned n;
            logic [31:0] rd;
            rd_t         e;
            n  = nregs(d);
            rd = (32'(v.raddr) < n) ? m[d][v.raddr] : 32'h0;
            if (v.we_b && 32'(v.addr_b) < n) m[d][v.addr_b] = merge(m[d][v.addr_b], v.data_b, v.be_b);
            if (v.we_a && 32'(v.addr_a) < n) m[d][v.addr_a] = merge(m[d][v.addr_a], v.data_a, v.be_a);
`ifdef REGFILE_WRITE_BYPASS_EN
            if (32'(v.raddr) < n) rd = m[d][v.raddr];
`endif
            if (v.re) begin
                e.data = rd;
                e.due  = cyc + 1 + lat(d);
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (d == 0) begin
                ec[0] = v.exp_coll;
                ea[0] = v.exp_aerr;
            end else begin
                ec[1] = f_coll(v, n);
                ea[1] = f_aerr(v, n);
            end
        end
        drive(v);
        cycle();
    endtask

    function automatic vec_t rd_vec(logic [2:0] a);
        vec_t v;
        v       = idle;
        v.re    = 1'b1;
        v.raddr = a;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 8; j++) m[d][j] = 32'h0;
            last[d] = 32'h0;
            ec[d]   = 1'b0;
            ea[d]   = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        idle = '{1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};

        //         we_a addr_a data_a        be_a     we_b addr_b data_b        be_b     re    raddr coll  aerr
        tbl[0]  = '{1'b1, 3'd2, 32'hAABBCCDD, 4'b0011, 1'b1, 3'd2, 32'h11223344, 4'b1100, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd5, 32'h00000001, 4'b1111, 1'b1, 3'd5, 32'h00000002, 4'b1111, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'd3, 32'h00000055, 4'b1111, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd7, 32'hDEADBEEF, 4'b1111, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd6, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'd1, 32'h12345678, 4'b0101, 1'b1, 3'd4, 32'hCAFEF00D, 4'b1111, 1'b1, 3'd7, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'd4, 32'h00000099, 4'b0001, 1'b1, 3'd4, 32'h00000077, 4'b0001, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 32'hFFFFFFFF, 4'b1111, 1'b1, 3'd0, 32'hFF000000, 4'b1000, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd7, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 3'd6, 32'h000000A1, 4'b0001, 1'b1, 3'd6, 32'h0000B2B2, 4'b0011, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 3'd6, 1'b0, 1'b0};

        // Reset state
        reset = 1'b0;
        drive(idle);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_valid", 0, 32'(if0.read_valid), 32'h0);
        chk("rst_read_data", 0, if0.read_data, 32'h0);
        chk("rst_collision", 0, 32'(if0.collision), 32'h0);
        chk("rst_addr_error", 1, 32'(if1.addr_error), 32'h0);
        chk("rst_read_valid", 1, 32'(if1.read_valid), 32'h0);
        reset = 1'b1;

        // Back-to-back reads of every address after reset
        for (int a = 0; a < 8; a++) begin
            v = rd_vec(3'(a));
            apply(v);
        end
        repeat (5) apply(idle);

        // Directed vector table
        for (int i = 0; i < 16; i++) apply(tbl[i]);
        repeat (5) apply(idle);

        // Four consecutive reads; dut1 must return four consecutive pulses four cycles later
        for (int a = 0; a < 4; a++) begin
            v = rd_vec(3'(a + 1));
            apply(v);
        end
        repeat (6) apply(idle);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            v.we_a   = 1'($urandom_range(0, 1));
            v.addr_a = 3'($urandom_range(0, 7));
            v.data_a = $urandom;
            v.be_a   = 4'($urandom_range(0, 15));
            v.we_b   = 1'($urandom_range(0, 1));
            v.addr_b = 3'($urandom_range(4, 7));
            v.data_b = $urandom;
            v.be_b   = 4'($urandom_range(0, 15));
            v.re     = 1'($urandom_range(0, 1));
            v.raddr  = 3'($urandom_range(0, 7));
            v.exp_coll = f_coll(v, 8);
            v.exp_aerr = f_aerr(v, 8);
            apply(v);
        end
        repeat (6) apply(idle);

        // Reset mid-stream: dut1 shows a valid beat with three reads still in flight
        for (int a = 0; a < 6; a++) begin
            v = rd_vec(3'(a));
            apply(v);
        end
        drive(idle);
        #2 reset = 1'b0;
        #1;
        chk("midrst_read_valid", 1, 32'(if1.read_valid), 32'h0);
        chk("midrst_read_data", 1, if1.read_data, 32'h0);
        chk("midrst_read_data", 0, if0.read_data, 32'h0);
        chk("midrst_read_valid", 0, 32'(if0.read_valid), 32'h0);
        model_reset();
        repeat (2) apply(idle);
        reset = 1'b1;
        repeat (8) apply(idle);

        // Memory contents after reset are back to init_value
        for (int a = 0; a < 8; a++) begin
            v = rd_vec(3'(a));
            apply(v);
        end
        repeat (6) apply(idle);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
